// File: rtl/memory_pkg.sv
// Shared definitions for the main-memory slice behind the cache.
// Default geometry, the controller state encoding and a width helper.
package memory_pkg;

    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 15;
    localparam int BLK_WORDS   = 4;
    localparam int MEM_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT
    } mem_state_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/block_memory_if.sv
// Request/response bundle between the cache (master) and main memory.
// Requests are levels sampled while the memory is idle.
interface block_memory_if #(
    parameter int WORD        = memory_pkg::WORD_W,
    parameter int ADDRESSL    = memory_pkg::ADDR_W,
    parameter int BLOCK_WORDS = memory_pkg::BLK_WORDS
);

    logic [ADDRESSL-1:0]         address;
    logic                        memRead;
    logic                        memWrite;
    logic [WORD-1:0]             writeData;
    logic [WORD-1:0]             dataOut;
    logic [BLOCK_WORDS*WORD-1:0] blockOut;
    logic                        memReady;
    logic                        busy;

    modport master (
        output address, memRead, memWrite, writeData,
        input  dataOut, blockOut, memReady, busy
    );

    modport slave (
        input  address, memRead, memWrite, writeData,
        output dataOut, blockOut, memReady, busy
    );

endinterface

// File: rtl/latency_counter.sv
// Loadable down-counter with a zero flag; used to time fixed-latency
// operations in cycles.
module latency_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/block_memory.sv
// Word-addressed main memory returning a whole cache block per read,
// with a fixed latency in cycles and a registered request handshake.
module block_memory
    import memory_pkg::*;
#(
    parameter int WORD        = WORD_W,
    parameter int LENGTH      = 32768,
    parameter int ADDRESSL    = ADDR_W,
    parameter int BLOCK_WORDS = BLK_WORDS,
    parameter int LATENCY     = MEM_LATENCY
) (
    input  logic           clk,
    input  logic           rst_n,
    block_memory_if.slave  bus
);

    localparam int OFF = clog2(BLOCK_WORDS);
    localparam int CW  = clog2(LATENCY) + 1;

    mem_state_t                  state;
    logic [ADDRESSL-1:0]         addr_q;
    logic [WORD-1:0]             wdata_q;
    logic [ADDRESSL-1:0]         base;
    logic [WORD-1:0]             rd_word;
    logic [BLOCK_WORDS*WORD-1:0] rd_block;
    logic                        accept;
    logic                        cnt_zero;
    logic                        rd_done;
    logic                        wr_done;

    // Words are stored XORed with their own address, so the all-zero
    // power-up array reads back as memory[i] = i.
    logic [WORD-1:0] mem [LENGTH] = '{default: '0};

    function automatic logic [WORD-1:0] key(input logic [ADDRESSL-1:0] a);
        return WORD'(a);
    endfunction

    assign accept  = (state == IDLE) && (bus.memRead || bus.memWrite);
    assign rd_done = (state == READ_WAIT) && cnt_zero;
    assign wr_done = (state == WRITE_WAIT) && cnt_zero;
    assign base    = {addr_q[ADDRESSL-1:OFF], {OFF{1'b0}}};
    assign rd_word = mem[addr_q] ^ key(addr_q);

    always_comb begin
        rd_block = '0;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            rd_block[i*WORD +: WORD] = mem[base | ADDRESSL'(i)]
                                     ^ key(base | ADDRESSL'(i));
        end
    end

    latency_counter #(
        .W (CW)
    ) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (CW'(LATENCY - 1)),
        .dec      (state != IDLE),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            bus.dataOut  <= '0;
            bus.blockOut <= '0;
            bus.memReady <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.memReady <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.memWrite) begin
                        addr_q   <= bus.address;
                        wdata_q  <= bus.writeData;
                        bus.busy <= 1'b1;
                        state    <= WRITE_WAIT;
                    end else if (bus.memRead) begin
                        addr_q   <= bus.address;
                        bus.busy <= 1'b1;
                        state    <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (rd_done) begin
                        bus.dataOut  <= rd_word;
                        bus.blockOut <= rd_block;
                        bus.memReady <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WRITE_WAIT: begin
                    if (wr_done) begin
                        bus.memReady <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never reset; a write aborted by reset leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst_n && wr_done) begin
            mem[addr_q] <= wdata_q ^ key(addr_q);
        end
    end

endmodule

// File: tb/tb_block_memory.sv
// Directed bench for block_memory: latency, block assembly, write priority,
// input capture, reset abort and back-to-back requests.
module tb_block_memory;

    logic clk = 1'b0;
    logic rst_n;
    int   ncmp = 0;
    int   nfail = 0;
    int   bn;
    int   pulses;
    bit   got;

    always #5 clk = ~clk;

    block_memory_if #(
        .WORD        (32),
        .ADDRESSL    (15),
        .BLOCK_WORDS (4)
    ) bus ();

    block_memory #(
        .WORD        (32),
        .LENGTH      (32768),
        .ADDRESSL    (15),
        .BLOCK_WORDS (4),
        .LATENCY     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle request and wait (bounded) for memReady.
    task automatic request(input logic rd, input logic wr,
                           input logic [14:0] a, input logic [31:0] d,
                           output int busy_n, output bit seen);
        bus.address   = a;
        bus.memRead   = rd;
        bus.memWrite  = wr;
        bus.writeData = d;
        busy_n = 0;
        seen   = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            bus.memRead  = 1'b0;
            bus.memWrite = 1'b0;
            if (bus.memReady === 1'b1) seen = 1'b1;
            else if (bus.busy === 1'b1) busy_n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.address   = '0;
        bus.memRead   = 1'b0;
        bus.memWrite  = 1'b0;
        bus.writeData = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_dataOut", bus.dataOut, 0);
        chk("rst_blockOut", bus.blockOut, 0);
        chk("rst_memReady", bus.memReady, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        request(1'b1, 1'b0, 15'h0006, 32'h0, bn, got);
        chk("rd6_ready", got, 1);
        chk("rd6_busy_cycles", bn, 4);
        chk("rd6_busy_low", bus.busy, 0);
        chk("rd6_dataOut", bus.dataOut, 32'h6);
        chk("rd6_block", bus.blockOut, {32'h7, 32'h6, 32'h5, 32'h4});
        @(negedge clk);
        chk("rd6_one_pulse", bus.memReady, 0);

        request(1'b0, 1'b1, 15'h0009, 32'hDEADBEEF, bn, got);
        chk("wr9_ready", got, 1);
        chk("wr9_busy_cycles", bn, 4);
        chk("wr9_data_held", bus.dataOut, 32'h6);
        @(negedge clk);
        request(1'b1, 1'b0, 15'h000A, 32'h0, bn, got);
        chk("rdA_ready", got, 1);
        chk("rdA_dataOut", bus.dataOut, 32'hA);
        chk("rdA_block", bus.blockOut,
            {32'hB, 32'hA, 32'hDEADBEEF, 32'h8});
        @(negedge clk);

        request(1'b1, 1'b1, 15'h0010, 32'h55, bn, got);
        chk("both_ready", got, 1);
        chk("both_busy_cycles", bn, 4);
        chk("both_data_held", bus.dataOut, 32'hA);
        chk("both_block_held", bus.blockOut,
            {32'hB, 32'hA, 32'hDEADBEEF, 32'h8});
        @(negedge clk);
        chk("both_one_pulse", bus.memReady, 0);
        request(1'b1, 1'b0, 15'h0010, 32'h0, bn, got);
        chk("rd10_ready", got, 1);
        chk("rd10_dataOut", bus.dataOut, 32'h55);
        chk("rd10_block", bus.blockOut,
            {32'h13, 32'h12, 32'h11, 32'h55});
        @(negedge clk);

        bus.address = 15'h0003;
        bus.memRead = 1'b1;
        @(negedge clk);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            bus.address = 15'h0100;
            bus.memRead = c[0];
            @(negedge clk);
            if (bus.memReady === 1'b1) got = 1'b1;
        end
        bus.memRead = 1'b0;
        chk("rd3_ready", got, 1);
        chk("rd3_dataOut", bus.dataOut, 32'h3);
        chk("rd3_block", bus.blockOut, {32'h3, 32'h2, 32'h1, 32'h0});
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.memReady !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        chk("rd3_no_second", pulses, 0);

        bus.address   = 15'h0020;
        bus.writeData = 32'h1234;
        bus.memWrite  = 1'b1;
        @(negedge clk);
        bus.memWrite = 1'b0;
        chk("wr20_busy", bus.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_dataOut", bus.dataOut, 0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.memReady !== 1'b0) pulses++;
        end
        chk("abort_no_ready", pulses, 0);
        request(1'b1, 1'b0, 15'h0020, 32'h0, bn, got);
        chk("rd20_ready", got, 1);
        chk("rd20_dataOut", bus.dataOut, 32'h20);
        chk("rd20_block", bus.blockOut,
            {32'h23, 32'h22, 32'h21, 32'h20});
        @(negedge clk);

        bus.address = 15'h7FFF;
        bus.memRead = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.memReady === 1'b1) got = 1'b1;
        end
        chk("top_ready", got, 1);
        chk("top_dataOut", bus.dataOut, 32'h7FFF);
        chk("top_block", bus.blockOut,
            {32'h7FFF, 32'h7FFE, 32'h7FFD, 32'h7FFC});
        @(negedge clk);
        chk("b2b_busy", bus.busy, 1);
        chk("b2b_ready_low", bus.memReady, 0);
        bus.memRead = 1'b0;
        bus.address = 15'h0004;
        bn  = 0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.memReady === 1'b1) got = 1'b1;
            else if (bus.busy === 1'b1) bn++;
        end
        chk("b2b_ready", got, 1);
        chk("b2b_busy_rest", bn, 3);
        chk("b2b_dataOut", bus.dataOut, 32'h7FFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
